// File: rtl/core_pkg.sv
// core_pkg: shared core widths and the register-file checker state encoding.
package core_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  typedef enum logic [2:0] {IDLE, SETTLE, READ, CMP, DONE} regchk_state_e;
endpackage

// File: rtl/regchk_table.sv
// regchk_table: expected-value table, one write port and one async read port.
module regchk_table
  import core_pkg::*;
#(
  parameter  int NUM_CHECKS = 16,
  localparam int IW         = $clog2(NUM_CHECKS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [IW-1:0]             i_widx,
  input  logic                      i_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic [IW-1:0]             i_ridx,
  output logic                      o_en,
  output logic [REG_ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0]     o_data
);
  logic                      r_en   [NUM_CHECKS];
  logic [REG_ADDR_WIDTH-1:0] r_addr [NUM_CHECKS];
  logic [DATA_WIDTH-1:0]     r_data [NUM_CHECKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        r_en[i]   <= 1'b0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (i_we) begin
      r_en[i_widx]   <= i_en;
      r_addr[i_widx] <= i_addr;
      r_data[i_widx] <= i_data;
    end
  end

  assign o_en   = r_en[i_ridx];
  assign o_addr = r_addr[i_ridx];
  assign o_data = r_data[i_ridx];
endmodule

// File: rtl/regfile_checker.sv
// regfile_checker: reads table-listed registers after a settle delay and counts mismatches.
// Define REGCHK_FAIL_LOG_EN to build the first-mismatch log; otherwise fail_* are tied to 0.
module regfile_checker
  import core_pkg::*;
#(
  parameter  int NUM_CHECKS    = 16,
  parameter  int SETTLE_CYCLES = 30,
  localparam int IW            = $clog2(NUM_CHECKS),
  localparam int CW            = $clog2(NUM_CHECKS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cfg_we,
  input  logic [IW-1:0]             cfg_idx,
  input  logic                      cfg_en,
  input  logic [REG_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0]     cfg_data,
  output logic                      rf_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CW-1:0]             error_count,
  output logic [IW-1:0]             fail_idx,
  output logic [REG_ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0]     fail_exp,
  output logic [DATA_WIDTH-1:0]     fail_got
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

  regchk_state_e             r_state;
  logic [IW-1:0]             r_idx;
  logic [SW-1:0]             r_cnt;
  logic                      w_en;
  logic [REG_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]     w_exp;
  logic                      w_mis;
  logic                      w_last;
  logic                      w_go;

  regchk_table #(.NUM_CHECKS(NUM_CHECKS)) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (cfg_we && !busy),
    .i_widx (cfg_idx),
    .i_en   (cfg_en),
    .i_addr (cfg_addr),
    .i_data (cfg_data),
    .i_ridx (r_idx),
    .o_en   (w_en),
    .o_addr (w_addr),
    .o_data (w_exp)
  );

  assign busy       = r_state inside {SETTLE, READ, CMP};
  assign rf_rd_en   = r_state == READ && w_en;
  assign rf_rd_addr = rf_rd_en ? w_addr : '0;
  // Case inequality so an X/Z read-back is reported as a mismatch in simulation.
  assign w_mis      = rf_rd_data !== w_exp;
  assign w_last     = r_idx == IW'(NUM_CHECKS - 1);
  assign w_go       = !abort && start && (r_state == IDLE || r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      error_count <= '0;
    end else if (abort) begin
      r_state <= IDLE;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state     <= SETTLE_CYCLES == 0 ? READ : SETTLE;
          r_idx       <= '0;
          r_cnt       <= '0;
          done        <= 1'b0;
          pass        <= 1'b0;
          error_count <= '0;
        end
        SETTLE: if (r_cnt == SW'(SETTLE_CYCLES - 1)) r_state <= READ;
                else r_cnt <= r_cnt + 1'b1;
        READ: if (w_en) r_state <= CMP;
              else if (w_last) begin
                r_state <= DONE;
                done    <= 1'b1;
                pass    <= error_count == '0;
              end else r_idx <= r_idx + 1'b1;
        CMP: begin
          error_count <= error_count + CW'(w_mis);
          if (w_last) begin
            r_state <= DONE;
            done    <= 1'b1;
            pass    <= error_count == '0 && !w_mis;
          end else begin
            r_state <= READ;
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef REGCHK_FAIL_LOG_EN
  logic [IW-1:0]             r_fidx;
  logic [REG_ADDR_WIDTH-1:0] r_faddr;
  logic [DATA_WIDTH-1:0]     r_fexp;
  logic [DATA_WIDTH-1:0]     r_fgot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_go) begin
      r_fidx  <= '0;
      r_faddr <= '0;
      r_fexp  <= '0;
      r_fgot  <= '0;
    end else if (!abort && r_state == CMP && w_mis && error_count == '0) begin
      r_fidx  <= r_idx;
      r_faddr <= w_addr;
      r_fexp  <= w_exp;
      r_fgot  <= rf_rd_data;
    end
  end

  assign fail_idx  = r_fidx;
  assign fail_addr = r_faddr;
  assign fail_exp  = r_fexp;
  assign fail_got  = r_fgot;
`else
  assign fail_idx  = '0;
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_got  = '0;
`endif
endmodule
